// File: rtl/pingpong_frame_ctrl_pkg.sv
// Shared types and defaults for the ping-pong frame buffer controller.
package pingpong_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    typedef enum logic {
        W_FILL,
        W_FULL
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_DRAIN
    } rd_state_t;

endpackage

// File: rtl/pingpong_frame_ctrl_read_seq.sv
// Reader side of the ping-pong buffer: walks one bank 0..DEPTH-1 and
// re-times the RAM read data into out_data with a two-cycle latency.
module pp_read_sequencer
    import pingpong_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              frame_start,
    input  logic              frame_avail,
    input  logic              sel_next,
    output logic              idle,
    output logic              re,
    output logic [ADDR_W-1:0] raddr,
    output logic              rd_sel,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done,
    output logic              underrun,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rd_state_t         state;
    logic [ADDR_W-1:0] rd_ptr;
    logic              vld_p0;
    logic              last_p0;
    logic              vld_p1;
    logic              last_p1;

    assign idle    = (state == R_IDLE);
    assign busy    = ~idle;
    assign re      = (state == R_READ);
    assign raddr   = rd_ptr;
    assign vld_p0  = re;
    assign last_p0 = re && (rd_ptr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= R_IDLE;
            rd_ptr     <= '0;
            rd_sel     <= BANK0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            // p0 -> p1: RAM presents rdata for the address issued last cycle
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            // p1 -> output register
            out_valid  <= vld_p1;
            frame_done <= last_p1;
            if (vld_p1) begin
                out_data <= rdata;
            end
            underrun <= 1'b0;

            case (state)
                R_IDLE: begin
                    if (frame_start) begin
                        if (frame_avail) begin
                            state  <= R_READ;
                            rd_sel <= sel_next;
                            rd_ptr <= '0;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                R_READ: begin
                    if (rd_ptr == LAST_ADDR) begin
                        rd_ptr <= '0;
                        state  <= R_DRAIN;
                    end else begin
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                    end
                end
                R_DRAIN: begin
                    // frame_done is high while the final word sits on out_data
                    if (frame_done) begin
                        state <= R_IDLE;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong frame buffer controller: producer fills one bank while the
// display reader streams the other; banks swap only between frames.
module pingpong_frame_ctrl
    import pingpong_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              frame_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done,
    output logic              underrun,
    output logic              busy,
    output logic              wr_bank,
    output logic              bank0_we,
    output logic [ADDR_W-1:0] bank0_waddr,
    output logic [DATA_W-1:0] bank0_wdata,
    output logic              bank0_re,
    output logic [ADDR_W-1:0] bank0_raddr,
    input  logic [DATA_W-1:0] bank0_rdata,
    output logic              bank1_we,
    output logic [ADDR_W-1:0] bank1_waddr,
    output logic [DATA_W-1:0] bank1_wdata,
    output logic              bank1_re,
    output logic [ADDR_W-1:0] bank1_raddr,
    input  logic [DATA_W-1:0] bank1_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    wr_state_t         wstate;
    logic [ADDR_W-1:0] wr_ptr;
    logic              bank_valid;
    logic              accept;
    logic              swap;
    logic              rd_idle;
    logic              rd_re;
    logic              rd_sel;
    logic [ADDR_W-1:0] rd_raddr;
    logic [DATA_W-1:0] rd_rdata;

    assign in_ready = (wstate == W_FILL);
    assign accept   = in_valid && in_ready;
    // A completed frame is handed over only while the reader sits idle
    assign swap     = (wstate == W_FULL) && rd_idle;

    assign bank0_we    = accept && (wr_bank == BANK0);
    assign bank1_we    = accept && (wr_bank == BANK1);
    assign bank0_waddr = wr_ptr;
    assign bank1_waddr = wr_ptr;
    assign bank0_wdata = in_data;
    assign bank1_wdata = in_data;

    assign bank0_re    = rd_re && (rd_sel == BANK0);
    assign bank1_re    = rd_re && (rd_sel == BANK1);
    assign bank0_raddr = rd_raddr;
    assign bank1_raddr = rd_raddr;
    assign rd_rdata    = (rd_sel == BANK1) ? bank1_rdata : bank0_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wstate     <= W_FILL;
            wr_ptr     <= '0;
            wr_bank    <= BANK0;
            bank_valid <= 1'b0;
        end else if (swap) begin
            wr_bank    <= ~wr_bank;
            wstate     <= W_FILL;
            bank_valid <= 1'b1;
        end else if (accept) begin
            if (wr_ptr == LAST_ADDR) begin
                wr_ptr <= '0;
                wstate <= W_FULL;
            end else begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

    // A frame_start coinciding with a swap takes the bank just completed
    pp_read_sequencer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_read_seq (
        .clk        (clk),
        .resetn     (resetn),
        .frame_start(frame_start),
        .frame_avail(bank_valid || swap),
        .sel_next   (swap ? wr_bank : ~wr_bank),
        .idle       (rd_idle),
        .re         (rd_re),
        .raddr      (rd_raddr),
        .rd_sel     (rd_sel),
        .rdata      (rd_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done),
        .underrun   (underrun),
        .busy       (busy)
    );

endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// Bench for pingpong_frame_ctrl: transaction-level frame model feeding a
// scoreboard, with behavioural RAM banks attached to the bank ports.
module tb_pingpong_frame_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              frame_start;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              frame_done;
    logic              underrun;
    logic              busy;
    logic              wr_bank;
    logic              bank0_we, bank1_we, bank0_re, bank1_re;
    logic [ADDR_W-1:0] bank0_waddr, bank1_waddr, bank0_raddr, bank1_raddr;
    logic [DATA_W-1:0] bank0_wdata, bank1_wdata;
    logic [DATA_W-1:0] bank0_rdata = '0;
    logic [DATA_W-1:0] bank1_rdata = '0;

    always #5 clk = ~clk;

    pingpong_frame_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .frame_start(frame_start), .out_valid(out_valid), .out_data(out_data),
        .frame_done(frame_done), .underrun(underrun), .busy(busy), .wr_bank(wr_bank),
        .bank0_we(bank0_we), .bank0_waddr(bank0_waddr), .bank0_wdata(bank0_wdata),
        .bank0_re(bank0_re), .bank0_raddr(bank0_raddr), .bank0_rdata(bank0_rdata),
        .bank1_we(bank1_we), .bank1_waddr(bank1_waddr), .bank1_wdata(bank1_wdata),
        .bank1_re(bank1_re), .bank1_raddr(bank1_raddr), .bank1_rdata(bank1_rdata)
    );

    // Behavioural banks: write-through on we, registered read one cycle after re
    logic [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1] = '{default: '0};
    logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1] = '{default: '0};

    always @(posedge clk) begin
        if (bank0_we) mem0[bank0_waddr] <= bank0_wdata;
        if (bank1_we) mem1[bank1_waddr] <= bank1_wdata;
        if (bank0_re) bank0_rdata <= mem0[bank0_raddr];
        if (bank1_re) bank1_rdata <= mem1[bank1_raddr];
    end

    typedef struct {
        logic [DATA_W-1:0] d;
        bit                last;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] m_fill[$];
    logic [DATA_W-1:0] m_ready[$];
    int                m_busy_left;
    bit                m_wr_bank;
    bit                m_rd_bank;
    bit                m_have;
    bit                m_underrun;
    int                cyc = 0;
    bit                chk_en = 1'b0;
    int                tests = 0;
    int                failed = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkv(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one frame in the fill buffer, one published frame,
    // and a reader that is busy for DEPTH+2 cycles per accepted frame_start.
    initial begin
        bit idle_m, full_m, swap_m, under_nxt;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                sb.delete();
                m_fill.delete();
                m_ready.delete();
                m_busy_left = 0;
                m_wr_bank   = 1'b0;
                m_rd_bank   = 1'b0;
                m_have      = 1'b0;
                m_underrun  = 1'b0;
            end else begin
                idle_m    = (m_busy_left == 0);
                full_m    = (m_fill.size() == DEPTH);
                swap_m    = full_m && idle_m;
                under_nxt = 1'b0;
                if (frame_start && idle_m) begin
                    if (m_have || swap_m) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            exp_t e;
                            e.d    = swap_m ? m_fill[i] : m_ready[i];
                            e.last = (i == DEPTH - 1);
                            e.cyc  = cyc + 3 + i;
                            sb.push_back(e);
                        end
                        m_rd_bank   = swap_m ? m_wr_bank : ~m_wr_bank;
                        m_busy_left = DEPTH + 2;
                    end else begin
                        under_nxt = 1'b1;
                    end
                end else if (m_busy_left > 0) begin
                    m_busy_left--;
                end
                if (swap_m) begin
                    m_ready   = m_fill;
                    m_fill.delete();
                    m_have    = 1'b1;
                    m_wr_bank = ~m_wr_bank;
                end else if (in_valid && !full_m) begin
                    m_fill.push_back(in_data);
                end
                m_underrun = under_nxt;
            end
            cyc++;
        end
    end

    // Monitor: compares every observable against the model mid-cycle
    initial begin
        bit   exp_we, exp_re, exp_out;
        int   rd_addr;
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_we  = in_valid && (m_fill.size() < DEPTH);
                exp_re  = (m_busy_left > 2);
                rd_addr = DEPTH + 2 - m_busy_left;
                check1("in_ready", in_ready, m_fill.size() < DEPTH);
                check1("busy", busy, m_busy_left != 0);
                check1("wr_bank", wr_bank, m_wr_bank);
                check1("underrun", underrun, m_underrun);
                check1("bank0_we", bank0_we, exp_we && !m_wr_bank);
                check1("bank1_we", bank1_we, exp_we && m_wr_bank);
                if (exp_we) begin
                    checkv("waddr", m_wr_bank ? int'(bank1_waddr) : int'(bank0_waddr), m_fill.size());
                    checkv("wdata", m_wr_bank ? int'(bank1_wdata) : int'(bank0_wdata), int'(in_data));
                end
                check1("bank0_re", bank0_re, exp_re && !m_rd_bank);
                check1("bank1_re", bank1_re, exp_re && m_rd_bank);
                if (exp_re) begin
                    checkv("raddr", m_rd_bank ? int'(bank1_raddr) : int'(bank0_raddr), rd_addr);
                end
                exp_out = (sb.size() > 0) && (sb[0].cyc == cyc);
                check1("out_valid", out_valid, exp_out);
                if (exp_out) begin
                    e = sb.pop_front();
                    checkv("out_data", int'(out_data), int'(e.d));
                    check1("frame_done", frame_done, e.last);
                end else begin
                    check1("frame_done_idle", frame_done, 1'b0);
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic fill(input logic [DATA_W-1:0] base);
        int n = 0;
        int guard = 0;
        bit acc;
        while (n < DEPTH && guard < 500) begin
            in_valid = 1'b1;
            in_data  = base + DATA_W'(n);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) n++;
            guard++;
        end
        in_valid = 1'b0;
        tests++;
        if (n < DEPTH) begin
            failed++;
            $display("FAIL fill_timeout: accepted %0d words expected %0d", n, DEPTH);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle_cycles(1);
        resetn = 1'b1;

        // Underrun straight out of reset
        pulse_start();
        idle_cycles(4);

        // First fill, then stream it
        fill(8'h00);
        idle_cycles(2);
        pulse_start();
        idle_cycles(40);

        // Second frame completes while the first is being re-read
        fork
            pulse_start();
            fill(8'h80);
        join
        idle_cycles(40);
        pulse_start();
        idle_cycles(40);

        // Writer completes in the same idle cycle as frame_start, then repeat
        fill(8'h40);
        pulse_start();
        idle_cycles(40);
        pulse_start();
        idle_cycles(40);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid    = ($urandom_range(0, 1) == 1);
            in_data     = DATA_W'($urandom);
            frame_start = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        in_valid    = 1'b0;
        frame_start = 1'b0;
        idle_cycles(40);

        // Reset while word 10 of a frame is on the output
        fill(8'hC0);
        idle_cycles(3);
        pulse_start();
        idle_cycles(12);
        resetn = 1'b0;
        idle_cycles(1);
        resetn = 1'b1;
        idle_cycles(3);
        pulse_start();
        idle_cycles(10);

        checkv("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
